fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
- Single-issue FPU front-end that sits between the decode/load-store stage and the FPU arithmetic core.
- Owns the FP register file, the sticky fflags accumulator and dynamic rounding-mode resolution.
- Sequences loads, stores and arithmetic ops through valid/ready request and response handshakes, and a start/done handshake to the core.
- Generalises the earlier fixed 32-bit FPU interface: FLEN and register count are parametrised, back-pressure is explicit, and core latency is variable.

Parameters:
FLEN, 32, FP data width in bits
NREG, 32, number of FP registers
WDOG_CYCLES, 64, watchdog limit in cycles; used only with FPU_WATCHDOG_EN
(localparam REG_W = $clog2(NREG))

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  2  00 ARITH, 01 LOAD, 10 STORE, 11 reserved (treated as illegal)
req_funct7  in  7  arithmetic operation select
req_rs1  in  REG_W  source register 1
req_rs2  in  REG_W  source register 2
req_rd  in  REG_W  destination register
req_frm  in  3  instruction rounding mode; 111 = dynamic
fcsr_frm  in  3  rounding mode from the CSR
dload_ext  in  FLEN  load data
core_start  out  1  one-cycle launch pulse to the core
core_op_a  out  FLEN  operand a to the core
core_op_b  out  FLEN  operand b to the core
core_funct7  out  7  operation select to the core
core_frm  out  3  resolved rounding mode
core_done  in  1  core result valid (one-cycle pulse)
core_result  in  FLEN  core result
core_flags  in  5  NV,DZ,OF,UF,NX
resp_valid  out  1  operation complete
resp_ready  in  1  consumer accepts the response
resp_store_data  out  FLEN  RF[rs2] for STORE
resp_flags  out  5  flags raised by this op
resp_illegal  out  1  illegal rounding mode or op
resp_timeout  out  1  watchdog abort
fflags  out  5  sticky accumulated flags
fflags_clr  in  1  clear sticky flags

Behaviour:
- Reset: state IDLE; all RF entries 0; fflags 0; all outputs 0 except req_ready. Reset mid-operation discards the op, performs no writeback, and leaves no response pending. The core shares n_rst.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1. Accept when req_valid&req_ready. Operands are read combinationally in the accept cycle.
  - LOAD: RF[rd]<=dload_ext at the accept edge; go to RESP.
  - STORE: latch RF[rs2] into resp_store_data; go to RESP.
  - ARITH: rm = (req_frm==111) ? fcsr_frm : req_frm. If rm is in {101,110,111}, or op is 11: no launch, no write, resp_illegal=1; go to RESP. Otherwise latch operands, funct7 and rm; go to EXEC.
- EXEC:
  - req_ready=0. core_start=1 in the first EXEC cycle only.
  - On core_done: RF[rd]<=core_result, resp_flags<=core_flags, fflags|=core_flags; go to RESP.
  - core_done in the same cycle as core_start is legal.
- RESP:
  - resp_valid=1 and resp_* held stable until resp_ready; then go to IDLE and clear resp_*.
  - No new request is accepted while in RESP.
- Latency:
  - LOAD/STORE/illegal: resp_valid in the cycle after accept.
  - ARITH: core_start in the cycle after accept; resp_valid in the cycle after core_done.
- core_done outside EXEC is ignored.
- fflags_next = (fflags_clr ? 0 : fflags) | new_flags. When clear and accumulate coincide, the new flags survive.
- Writing rd=x0 is allowed; FP registers are not hardwired to zero.

Optional Feature:
- FPU_WATCHDOG_EN defined:
  - A counter runs in EXEC. If WDOG_CYCLES cycles elapse without core_done, abort: no writeback, fflags unchanged, resp_timeout=1, resp_flags=0; go to RESP.
  - A core_done arriving on the limit cycle wins over the abort.
- Undefined: no counter; resp_timeout is tied to 0; EXEC waits indefinitely.

Decomposition:
- fpu_ctrl_pkg:
  - op enum (ARITH/LOAD/STORE)
  - state enum (IDLE/EXEC/RESP)
  - rounding-mode constants (RNE 000 … DYN 111)
  - flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0
- Sub-module fpu_regfile: NREG x FLEN, two async read ports, one write port, asynchronous reset to 0.

Test Plan:
- LOAD rd=3, dload_ext=0x3F800000, then STORE rs2=3 -> STORE response has resp_store_data=0x3F800000; each response arrives 1 cycle after accept.
- ARITH req_frm=111, fcsr_frm=001; core returns done 4 cycles after start with result 0x40000000, flags 00001 -> core_frm=001, RF[rd]=0x40000000, fflags=00001, resp_flags=00001.
- ARITH req_frm=101 -> no core_start, resp_illegal=1, RF unchanged. Repeat with req_frm=111, fcsr_frm=110 -> same response.
- Hold resp_ready=0 for 5 cycles -> resp_valid and payload stay stable and req_ready=0; the next request is accepted only after the handshake.
- fflags=00001; fflags_clr asserted in the same cycle as core_done with flags 10000 -> fflags=10000.
- FPU_WATCHDOG_EN, WDOG_CYCLES=8, core never completes -> resp_timeout=1 in the cycle after the limit, no RF write. Separately, assert n_rst mid-EXEC -> IDLE with all state zeroed.

Source files
------------

// File: rtl/fpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_ctrl_pkg
// Purpose  : Shared types and constants for the FPU issue controller:
//            request op encoding, FSM states, rounding modes, flag indices.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ARITH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10
  } op_e;

  // Encoding 2'b11 on req_op is reserved and reported as illegal.
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [2:0] RM_RNE  = 3'b000;
  localparam logic [2:0] RM_RTZ  = 3'b001;
  localparam logic [2:0] RM_RDN  = 3'b010;
  localparam logic [2:0] RM_RUP  = 3'b011;
  localparam logic [2:0] RM_RMM  = 3'b100;
  localparam logic [2:0] RM_RSV5 = 3'b101;
  localparam logic [2:0] RM_RSV6 = 3'b110;
  localparam logic [2:0] RM_DYN  = 3'b111;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Dynamic rounding mode defers to the CSR value.
  function automatic logic [2:0] resolve_rm(input logic [2:0] instr_rm,
                                            input logic [2:0] csr_rm);
    return (instr_rm == RM_DYN) ? csr_rm : instr_rm;
  endfunction

  // After resolution only RNE..RMM are executable; DYN in the CSR is illegal.
  function automatic logic rm_is_illegal(input logic [2:0] rm);
    return (rm == RM_RSV5) || (rm == RM_RSV6) || (rm == RM_DYN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_ctrl_if
// Purpose  : Request, response and core start/done bundle of the FPU issue
//            controller. master = decode/LSU/core side, slave = controller.
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_issue_ctrl_if #(
  parameter int FLEN = 32,
  parameter int NREG = 32
);
  localparam int REG_W = $clog2(NREG);

  // request channel
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [6:0]       req_funct7;
  logic [REG_W-1:0] req_rs1;
  logic [REG_W-1:0] req_rs2;
  logic [REG_W-1:0] req_rd;
  logic [2:0]       req_frm;

  // arithmetic core channel
  logic             core_start;
  logic [FLEN-1:0]  core_op_a;
  logic [FLEN-1:0]  core_op_b;
  logic [6:0]       core_funct7;
  logic [2:0]       core_frm;
  logic             core_done;
  logic [FLEN-1:0]  core_result;
  logic [4:0]       core_flags;

  // response channel
  logic             resp_valid;
  logic             resp_ready;
  logic [FLEN-1:0]  resp_store_data;
  logic [4:0]       resp_flags;
  logic             resp_illegal;
  logic             resp_timeout;

  modport master (
    output req_valid, req_op, req_funct7, req_rs1, req_rs2, req_rd, req_frm,
    output core_done, core_result, core_flags, resp_ready,
    input  req_ready, core_start, core_op_a, core_op_b, core_funct7, core_frm,
    input  resp_valid, resp_store_data, resp_flags, resp_illegal, resp_timeout
  );

  modport slave (
    input  req_valid, req_op, req_funct7, req_rs1, req_rs2, req_rd, req_frm,
    input  core_done, core_result, core_flags, resp_ready,
    output req_ready, core_start, core_op_a, core_op_b, core_funct7, core_frm,
    output resp_valid, resp_store_data, resp_flags, resp_illegal, resp_timeout
  );

endinterface
`default_nettype wire

// File: rtl/fpu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : fpu_regfile
// Purpose  : NREG x FLEN floating-point register file, two asynchronous
//            read ports, one synchronous write port, async clear to zero.
//            Entry 0 is an ordinary register (not hardwired).
// Revision : 1.0 - initial release
// ============================================================================
module fpu_regfile #(
  parameter  int FLEN  = 32,
  parameter  int NREG  = 32,
  localparam int REG_W = $clog2(NREG)
) (
  input  wire logic             clk,
  input  wire logic             n_rst,
  input  wire logic [REG_W-1:0] raddr_a_i,
  output      logic [FLEN-1:0]  rdata_a_o,
  input  wire logic [REG_W-1:0] raddr_b_i,
  output      logic [FLEN-1:0]  rdata_b_o,
  input  wire logic             we_i,
  input  wire logic [REG_W-1:0] waddr_i,
  input  wire logic [FLEN-1:0]  wdata_i
);

  logic [FLEN-1:0] regs_q [NREG];

  // Storage: cleared on reset, single write per cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_ctrl
// Purpose  : Single-issue FPU front-end. Owns the FP register file, sticky
//            fflags and rounding-mode resolution; sequences LOAD, STORE and
//            ARITH ops through IDLE -> (EXEC) -> RESP.
// Options  : FPU_WATCHDOG_EN - abort EXEC after WDOG_CYCLES cycles without
//            core_done (resp_timeout=1). Undefined: EXEC waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_ctrl #(
  parameter int FLEN        = 32,
  parameter int NREG        = 32,
  parameter int WDOG_CYCLES = 64
) (
  input  wire logic            clk,
  input  wire logic            n_rst,
  fpu_issue_ctrl_if.slave      bus,
  input  wire logic [2:0]      fcsr_frm,
  input  wire logic [FLEN-1:0] dload_ext,
  output      logic [4:0]      fflags,
  input  wire logic            fflags_clr
);
  import fpu_ctrl_pkg::*;

  localparam int REG_W = $clog2(NREG);

  state_e           state_q;
  logic             start_q;
  logic [REG_W-1:0] rd_q;
  logic [FLEN-1:0]  op_a_q;
  logic [FLEN-1:0]  op_b_q;
  logic [6:0]       funct7_q;
  logic [2:0]       frm_q;
  logic [FLEN-1:0]  resp_store_data_q;
  logic [4:0]       resp_flags_q;
  logic             resp_illegal_q;
  logic             resp_timeout_q;
  logic [4:0]       fflags_q;
  logic [4:0]       fflags_d;

  logic [FLEN-1:0]  rs1_data;
  logic [FLEN-1:0]  rs2_data;
  logic             rf_we;
  logic [REG_W-1:0] rf_waddr;
  logic [FLEN-1:0]  rf_wdata;

  logic [2:0]       rm_res;
  logic             accept;
  logic             is_load;
  logic             is_store;
  logic             arith_ok;
  logic             exec_done;
  logic [4:0]       new_flags;

`ifdef FPU_WATCHDOG_EN
  localparam int               WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              wdog_hit;
  assign wdog_hit = (wdog_cnt_q == WDOG_LAST);
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES != 0);
`endif

  fpu_regfile #(
    .FLEN (FLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk       (clk),
    .n_rst     (n_rst),
    .raddr_a_i (bus.req_rs1),
    .rdata_a_o (rs1_data),
    .raddr_b_i (bus.req_rs2),
    .rdata_b_o (rs2_data),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata)
  );

  // Request decode, flag accumulation and register-file write selection.
  always_comb begin
    rm_res    = resolve_rm(bus.req_frm, fcsr_frm);
    accept    = (state_q == ST_IDLE) && bus.req_valid;
    is_load   = (bus.req_op == OP_LOAD);
    is_store  = (bus.req_op == OP_STORE);
    arith_ok  = (bus.req_op == OP_ARITH) && !rm_is_illegal(rm_res);
    exec_done = (state_q == ST_EXEC) && bus.core_done;
    new_flags = exec_done ? bus.core_flags : 5'b0;
    // a clear coinciding with new flags keeps the new flags
    fflags_d  = (fflags_clr ? 5'b0 : fflags_q) | new_flags;

    rf_we    = 1'b0;
    rf_waddr = bus.req_rd;
    rf_wdata = dload_ext;
    if (accept && is_load) begin
      rf_we = 1'b1;
    end else if (exec_done) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = bus.core_result;
    end
  end

  // Control FSM with registered core launch and response payload.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q           <= ST_IDLE;
      start_q           <= 1'b0;
      rd_q              <= '0;
      op_a_q            <= '0;
      op_b_q            <= '0;
      funct7_q          <= '0;
      frm_q             <= '0;
      resp_store_data_q <= '0;
      resp_flags_q      <= '0;
      resp_illegal_q    <= 1'b0;
      resp_timeout_q    <= 1'b0;
      fflags_q          <= '0;
`ifdef FPU_WATCHDOG_EN
      wdog_cnt_q        <= '0;
`endif
    end else begin
      start_q  <= 1'b0;
      fflags_q <= fflags_d;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_RESP;
            if (is_load) begin
              // write already performed through the register-file port
            end else if (is_store) begin
              resp_store_data_q <= rs2_data;
            end else if (arith_ok) begin
              op_a_q   <= rs1_data;
              op_b_q   <= rs2_data;
              funct7_q <= bus.req_funct7;
              frm_q    <= rm_res;
              rd_q     <= bus.req_rd;
              start_q  <= 1'b1;
              state_q  <= ST_EXEC;
`ifdef FPU_WATCHDOG_EN
              wdog_cnt_q <= '0;
`endif
            end else begin
              resp_illegal_q <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (bus.core_done) begin
            resp_flags_q <= bus.core_flags;
            state_q      <= ST_RESP;
          end
`ifdef FPU_WATCHDOG_EN
          else if (wdog_hit) begin
            resp_timeout_q <= 1'b1;
            resp_flags_q   <= '0;
            state_q        <= ST_RESP;
          end else begin
            wdog_cnt_q <= wdog_cnt_q + WDOG_ONE;
          end
`endif
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_store_data_q <= '0;
            resp_flags_q      <= '0;
            resp_illegal_q    <= 1'b0;
            resp_timeout_q    <= 1'b0;
            state_q           <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready       = (state_q == ST_IDLE);
  assign bus.resp_valid      = (state_q == ST_RESP);
  assign bus.core_start      = start_q;
  assign bus.core_op_a       = op_a_q;
  assign bus.core_op_b       = op_b_q;
  assign bus.core_funct7     = funct7_q;
  assign bus.core_frm        = frm_q;
  assign bus.resp_store_data = resp_store_data_q;
  assign bus.resp_flags      = resp_flags_q;
  assign bus.resp_illegal    = resp_illegal_q;
  assign bus.resp_timeout    = resp_timeout_q;
  assign fflags              = fflags_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_issue_ctrl
// Purpose  : Directed self-checking bench for fpu_issue_ctrl. The watchdog
//            scenario runs only when FPU_WATCHDOG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_ctrl;
  import fpu_ctrl_pkg::*;

  localparam int FLEN = 32;
  localparam int NREG = 32;
  localparam int WDOG = 8;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [2:0]  fcsr_frm;
  logic [31:0] dload_ext;
  logic [4:0]  fflags;
  logic        fflags_clr;

  int n_cmp = 0;
  int n_bad = 0;

  fpu_issue_ctrl_if #(.FLEN(FLEN), .NREG(NREG)) bus ();

  fpu_issue_ctrl #(
    .FLEN        (FLEN),
    .NREG        (NREG),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus        (bus),
    .fcsr_frm   (fcsr_frm),
    .dload_ext  (dload_ext),
    .fflags     (fflags),
    .fflags_clr (fflags_clr)
  );

  always #5 clk = ~clk;

  // Present one request for one cycle; called and returns at a negedge.
  task automatic drive_req(input logic [1:0] op, input logic [6:0] f7,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [2:0] frm);
    bus.req_op     = op;
    bus.req_funct7 = f7;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.req_rd     = rd;
    bus.req_frm    = frm;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  task automatic finish_resp;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_funct7 = '0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rd = '0; bus.req_frm = '0;
    bus.core_done = 1'b0; bus.core_result = '0; bus.core_flags = '0;
    bus.resp_ready = 1'b0;
    fcsr_frm = '0; dload_ext = '0; fflags_clr = 1'b0;
    #1 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.core_start, bus.resp_illegal, bus.resp_timeout} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 10000",
        {bus.req_ready, bus.resp_valid, bus.core_start, bus.resp_illegal, bus.resp_timeout});
    end
    n_cmp++;
    if ({fflags, bus.resp_flags, bus.core_frm, bus.core_funct7} !== 20'h0) begin
      n_bad++; $display("FAIL reset_flags: got %h want 0", {fflags, bus.resp_flags, bus.core_frm, bus.core_funct7});
    end
    n_cmp++;
    if ({bus.resp_store_data, bus.core_op_a, bus.core_op_b} !== 96'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {bus.resp_store_data, bus.core_op_a, bus.core_op_b});
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_store;
    dload_ext = 32'h3F80_0000;
    drive_req(OP_LOAD, 7'h0, 5'd0, 5'd0, 5'd3, 3'b000);
    n_cmp++;
    if ({bus.resp_valid, bus.req_ready, bus.resp_illegal} !== 3'b100) begin
      n_bad++; $display("FAIL load_resp: got %b want 100", {bus.resp_valid, bus.req_ready, bus.resp_illegal});
    end
    finish_resp();
    n_cmp++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
      n_bad++; $display("FAIL load_release: got %b want 01", {bus.resp_valid, bus.req_ready});
    end
    drive_req(OP_STORE, 7'h0, 5'd0, 5'd3, 5'd0, 3'b000);
    n_cmp++;
    if ({bus.resp_valid, bus.resp_store_data} !== {1'b1, 32'h3F80_0000}) begin
      n_bad++; $display("FAIL store_data: got %b/%h want 1/3f800000", bus.resp_valid, bus.resp_store_data);
    end
    finish_resp();
    n_cmp++;
    if (bus.resp_store_data !== 32'h0) begin
      n_bad++; $display("FAIL store_clear: got %h want 0", bus.resp_store_data);
    end
  endtask

  task automatic test_arith_dyn;
    fcsr_frm = 3'b001;
    drive_req(OP_ARITH, 7'h01, 5'd3, 5'd0, 5'd5, 3'b111);
    n_cmp++;
    if ({bus.core_start, bus.core_frm, bus.core_funct7} !== {1'b1, 3'b001, 7'h01}) begin
      n_bad++; $display("FAIL arith_launch: got %b/%b/%h want 1/001/01", bus.core_start, bus.core_frm, bus.core_funct7);
    end
    n_cmp++;
    if ({bus.core_op_a, bus.core_op_b} !== {32'h3F80_0000, 32'h0}) begin
      n_bad++; $display("FAIL arith_operands: got %h/%h want 3f800000/0", bus.core_op_a, bus.core_op_b);
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.core_start, bus.resp_valid, bus.req_ready} !== 3'b000) begin
        n_bad++; $display("FAIL arith_wait%0d: got %b want 000", i, {bus.core_start, bus.resp_valid, bus.req_ready});
      end
    end
    @(negedge clk);
    bus.core_done = 1'b1; bus.core_result = 32'h4000_0000; bus.core_flags = 5'b00001;
    @(negedge clk);
    bus.core_done = 1'b0; bus.core_result = '0; bus.core_flags = '0;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_flags, fflags} !== {1'b1, 5'b00001, 5'b00001}) begin
      n_bad++; $display("FAIL arith_resp: got %b/%b/%b want 1/00001/00001", bus.resp_valid, bus.resp_flags, fflags);
    end
    finish_resp();
    drive_req(OP_STORE, 7'h0, 5'd0, 5'd5, 5'd0, 3'b000);
    n_cmp++;
    if (bus.resp_store_data !== 32'h4000_0000) begin
      n_bad++; $display("FAIL arith_writeback: got %h want 40000000", bus.resp_store_data);
    end
    finish_resp();
  endtask

  task automatic test_illegal;
    drive_req(OP_ARITH, 7'h0, 5'd3, 5'd3, 5'd5, 3'b101);
    n_cmp++;
    if ({bus.core_start, bus.resp_valid, bus.resp_illegal, bus.resp_timeout} !== 4'b0110) begin
      n_bad++; $display("FAIL illegal_frm101: got %b want 0110", {bus.core_start, bus.resp_valid, bus.resp_illegal, bus.resp_timeout});
    end
    finish_resp();
    fcsr_frm = 3'b110;
    drive_req(OP_ARITH, 7'h0, 5'd3, 5'd3, 5'd5, 3'b111);
    n_cmp++;
    if ({bus.core_start, bus.resp_valid, bus.resp_illegal, bus.resp_timeout} !== 4'b0110) begin
      n_bad++; $display("FAIL illegal_dyn110: got %b want 0110", {bus.core_start, bus.resp_valid, bus.resp_illegal, bus.resp_timeout});
    end
    finish_resp();
    fcsr_frm = 3'b000;
    drive_req(OP_RSVD, 7'h0, 5'd3, 5'd3, 5'd5, 3'b000);
    n_cmp++;
    if ({bus.core_start, bus.resp_valid, bus.resp_illegal, bus.resp_timeout} !== 4'b0110) begin
      n_bad++; $display("FAIL illegal_op11: got %b want 0110", {bus.core_start, bus.resp_valid, bus.resp_illegal, bus.resp_timeout});
    end
    finish_resp();
    drive_req(OP_STORE, 7'h0, 5'd0, 5'd5, 5'd0, 3'b000);
    n_cmp++;
    if ({bus.resp_illegal, bus.resp_store_data} !== {1'b0, 32'h4000_0000}) begin
      n_bad++; $display("FAIL illegal_rf_kept: got %b/%h want 0/40000000", bus.resp_illegal, bus.resp_store_data);
    end
    finish_resp();
  endtask

  task automatic test_back_to_back;
    drive_req(OP_STORE, 7'h0, 5'd0, 5'd3, 5'd0, 3'b000);
    // a competing LOAD waits while the STORE response is stalled
    bus.req_op = OP_LOAD; bus.req_rd = 5'd8; dload_ext = 32'hDEAD_BEEF; bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.resp_valid, bus.req_ready, bus.resp_store_data} !== {1'b1, 1'b0, 32'h3F80_0000}) begin
        n_bad++; $display("FAIL stall%0d: got %b/%b/%h want 1/0/3f800000", i, bus.resp_valid, bus.req_ready, bus.resp_store_data);
      end
      @(negedge clk);
    end
    finish_resp();
    n_cmp++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
      n_bad++; $display("FAIL stall_release: got %b want 01", {bus.resp_valid, bus.req_ready});
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_store_data} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL queued_load: got %b/%h want 1/0", bus.resp_valid, bus.resp_store_data);
    end
    finish_resp();
    drive_req(OP_STORE, 7'h0, 5'd0, 5'd8, 5'd0, 3'b000);
    n_cmp++;
    if (bus.resp_store_data !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL queued_load_data: got %h want deadbeef", bus.resp_store_data);
    end
    finish_resp();
  endtask

  task automatic test_fflags;
    drive_req(OP_ARITH, 7'h02, 5'd0, 5'd0, 5'd9, 3'b000);
    // done in the launch cycle, coinciding with a clear
    bus.core_done = 1'b1; bus.core_result = 32'h11; bus.core_flags = 5'b10000; fflags_clr = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0; bus.core_result = '0; bus.core_flags = '0; fflags_clr = 1'b0;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_flags, fflags} !== {1'b1, 5'b10000, 5'b10000}) begin
      n_bad++; $display("FAIL fflags_clr_acc: got %b/%b/%b want 1/10000/10000", bus.resp_valid, bus.resp_flags, fflags);
    end
    finish_resp();
    bus.core_done = 1'b1; bus.core_flags = 5'b00100;
    @(negedge clk);
    bus.core_done = 1'b0; bus.core_flags = '0;
    n_cmp++;
    if ({bus.resp_valid, fflags} !== {1'b0, 5'b10000}) begin
      n_bad++; $display("FAIL stray_done: got %b/%b want 0/10000", bus.resp_valid, fflags);
    end
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    n_cmp++;
    if (fflags !== 5'b00000) begin
      n_bad++; $display("FAIL fflags_clear: got %b want 00000", fflags);
    end
    drive_req(OP_STORE, 7'h0, 5'd0, 5'd9, 5'd0, 3'b000);
    n_cmp++;
    if (bus.resp_store_data !== 32'h11) begin
      n_bad++; $display("FAIL same_cycle_wb: got %h want 00000011", bus.resp_store_data);
    end
    finish_resp();
  endtask

`ifdef FPU_WATCHDOG_EN
  task automatic test_watchdog;
    bus.core_result = 32'hBAD0_BAD0;
    drive_req(OP_ARITH, 7'h0, 5'd3, 5'd3, 5'd10, 3'b000);
    for (int k = 1; k <= WDOG; k++) begin
      n_cmp++;
      if (bus.resp_valid !== 1'b0) begin
        n_bad++; $display("FAIL wdog_early%0d: got %b want 0", k, bus.resp_valid);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({bus.resp_valid, bus.resp_timeout, bus.resp_illegal, bus.resp_flags, fflags} !== {3'b110, 10'h0}) begin
      n_bad++; $display("FAIL wdog_abort: got %b want 1100000000000",
        {bus.resp_valid, bus.resp_timeout, bus.resp_illegal, bus.resp_flags, fflags});
    end
    finish_resp();
    bus.core_result = '0;
    drive_req(OP_STORE, 7'h0, 5'd0, 5'd10, 5'd0, 3'b000);
    n_cmp++;
    if ({bus.resp_timeout, bus.resp_store_data} !== 33'h0) begin
      n_bad++; $display("FAIL wdog_no_wb: got %b/%h want 0/0", bus.resp_timeout, bus.resp_store_data);
    end
    finish_resp();
  endtask
`endif

  task automatic test_reset_mid_exec;
    drive_req(OP_ARITH, 7'h0, 5'd3, 5'd3, 5'd11, 3'b000);
    #1 n_rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.core_start, bus.resp_timeout} !== 4'b1000) begin
      n_bad++; $display("FAIL rst_exec_ctrl: got %b want 1000", {bus.req_ready, bus.resp_valid, bus.core_start, bus.resp_timeout});
    end
    n_cmp++;
    if ({bus.core_op_a, fflags} !== 37'h0) begin
      n_bad++; $display("FAIL rst_exec_data: got %h want 0", {bus.core_op_a, fflags});
    end
    @(negedge clk);
    n_rst = 1'b1;
    bus.core_done = 1'b1; bus.core_result = 32'h7777_7777;
    @(negedge clk);
    bus.core_done = 1'b0; bus.core_result = '0;
    n_cmp++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
      n_bad++; $display("FAIL rst_no_pending: got %b want 01", {bus.resp_valid, bus.req_ready});
    end
    drive_req(OP_STORE, 7'h0, 5'd0, 5'd3, 5'd0, 3'b000);
    n_cmp++;
    if (bus.resp_store_data !== 32'h0) begin
      n_bad++; $display("FAIL rst_rf_cleared: got %h want 0", bus.resp_store_data);
    end
    finish_resp();
    drive_req(OP_STORE, 7'h0, 5'd0, 5'd11, 5'd0, 3'b000);
    n_cmp++;
    if (bus.resp_store_data !== 32'h0) begin
      n_bad++; $display("FAIL rst_no_wb: got %h want 0", bus.resp_store_data);
    end
    finish_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_load_store();
    test_arith_dyn();
    test_illegal();
    test_back_to_back();
    test_fflags();
`ifdef FPU_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
